// File: rtl/deside.sv
// Registered majority-vote decider: counts yes votes across PERSON voters and
// registers the count, a strict-majority verdict and a tie flag every clock.
module deside #(
    parameter int PERSON = 6,
    localparam int CW = $clog2(PERSON + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PERSON-1:0] in,
    output logic              out,
    output logic              even,
    output logic [CW-1:0]     yes_cnt
);

    logic [CW-1:0] pop;
    logic [CW:0]   twice;
    logic [CW:0]   panel;
    logic          majority;
    logic          tie;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < PERSON; i++) begin
            pop = pop + CW'(in[i]);
        end
    end

    // Compare 2*yes against PERSON at CW+1 bits so no rounding or truncation occurs.
    always_comb begin
        twice    = {pop, 1'b0};
        panel    = (CW + 1)'(PERSON);
        majority = (twice > panel);
        tie      = (twice == panel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            yes_cnt <= '0;
            out     <= 1'b0;
            even    <= 1'b0;
        end else begin
            yes_cnt <= pop;
            out     <= majority;
            even    <= tie;
        end
    end

endmodule

// File: tb/tb_deside.sv
// Randomized self-checking bench for deside: a popcount/arithmetic model
// predicts every registered output for a 6-voter and a 5-voter panel.
module tb_deside;

    logic       clk;
    logic       rst;
    logic [5:0] in6;
    logic [4:0] in5;
    logic       out6, even6, out5, even5;
    logic [2:0] cnt6, cnt5;

    int vectors = 0;
    int errors  = 0;

    int m6_cnt, m6_out, m6_even;
    int m5_cnt, m5_out, m5_even;
    bit checking = 0;

    deside #(.PERSON(6)) dut6 (
        .clk(clk), .reset(rst), .in(in6), .out(out6), .even(even6), .yes_cnt(cnt6)
    );

    deside #(.PERSON(5)) dut5 (
        .clk(clk), .reset(rst), .in(in5), .out(out5), .even(even5), .yes_cnt(cnt5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: yes count is the number of ones; verdicts follow from 2*yes vs panel size.
    always @(posedge clk) begin
        if (rst) begin
            m6_cnt <= 0; m6_out <= 0; m6_even <= 0;
            m5_cnt <= 0; m5_out <= 0; m5_even <= 0;
        end else begin
            m6_cnt  <= $countones(in6);
            m6_out  <= (2 * $countones(in6) > 6) ? 1 : 0;
            m6_even <= (2 * $countones(in6) == 6) ? 1 : 0;
            m5_cnt  <= $countones(in5);
            m5_out  <= (2 * $countones(in5) > 5) ? 1 : 0;
            m5_even <= (2 * $countones(in5) == 5) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("p6 yes_cnt", int'(cnt6), m6_cnt);
            chk("p6 out", int'(out6), m6_out);
            chk("p6 even", int'(even6), m6_even);
            chk("p6 out&even exclusive", int'(out6 & even6), 0);
            chk("p5 yes_cnt", int'(cnt5), m5_cnt);
            chk("p5 out", int'(out5), m5_out);
            chk("p5 even never set", int'(even5), 0);
            chk("p5 out vs cnt>=3", int'(out5), (int'(cnt5) >= 3) ? 1 : 0);
        end
    end

    task automatic step_check(input string nm, input int c, input int o, input int e);
        @(posedge clk);
        @(negedge clk);
        chk({nm, " yes_cnt"}, int'(cnt6), c);
        chk({nm, " out"}, int'(out6), o);
        chk({nm, " even"}, int'(even6), e);
    endtask

    initial begin
        rst = 1'b1;
        in6 = 6'b111111;
        in5 = 5'b11111;
        checking = 1'b1;

        step_check("reset1", 0, 0, 0);
        step_check("reset2", 0, 0, 0);

        rst = 1'b0; in6 = 6'b000111;
        step_check("tie", 3, 0, 1);
        in6 = 6'b010111;
        step_check("four", 4, 1, 0);
        in6 = 6'b000011;
        step_check("two", 2, 0, 0);
        in6 = 6'b000000;
        step_check("allzero", 0, 0, 0);
        in6 = 6'b111111;
        step_check("allone", 6, 1, 0);

        in6 = 6'b111100; rst = 1'b1;
        step_check("midreset", 0, 0, 0);
        rst = 1'b0;
        step_check("afterreset", 4, 1, 0);

        for (int n = 0; n < 200; n++) begin
            in6 = 6'($urandom);
            in5 = 5'($urandom);
            rst = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
